// File: rtl/cipher_arb_pkg.sv
// Shared types and constants for the cipher frame arbiter and its cipher datapath.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package cipher_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEY_RST = 2'd1,
    STREAM  = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Key phase length in bytes; every frame restarts at phase 0
  localparam int KEY_LEN = 4;

  // Key bytes, phase 0 in the most significant byte
  localparam logic [8*KEY_LEN-1:0] KEY_BYTES = 32'hDEAD_BEEF;

  // Minimum index width needed to address n items (never less than 1 bit)
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cipher_frame_arbiter_if.sv
// Requester-side byte-stream bundle: one valid/ready/last lane and one byte lane per requester.
// Latency: n/a (wires only).
// Backpressure: req_ready per lane, driven by the arbiter.
interface cipher_frame_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  // Requester (front-end) side
  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  // Arbiter side
  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request searching upward from ptr, wrapping at NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to latch idx.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  // Scan offsets from farthest to nearest so the nearest asserted request wins
  always_comb begin
    int j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        any = 1'b1;
        idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/xor_cipher.sv
// Byte XOR cipher with a repeating KEY_LEN-byte key; the key phase advances once per valid byte.
// Latency: one cycle from data_valid to data_out_valid.
// Backpressure: none; accepts a byte every cycle. rst (active high, synchronous) returns the phase to 0.
module xor_cipher
  import cipher_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] data_out,
  output logic       data_out_valid
);

  localparam int KIW = id_width(KEY_LEN);

  logic [KIW-1:0] key_idx;
  logic [7:0]     key_byte;

  // Select the key byte for the current phase
  always_comb begin
    key_byte = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (key_idx == KIW'(i)) key_byte = KEY_BYTES[8*(KEY_LEN-1-i) +: 8];
    end
  end

  // Encipher one byte per valid cycle and step the key phase
  always_ff @(posedge clk) begin
    if (rst) begin
      key_idx        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= data_valid;
      if (data_valid) begin
        data_out <= data_in ^ key_byte;
        key_idx  <= (key_idx == KIW'(KEY_LEN - 1)) ? '0 : key_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cipher_frame_arbiter.sv
// Whole-frame round-robin sharing of one xor_cipher among NUM_REQ byte streams; key phase resynced per frame.
// Latency: byte accepted in cycle T appears on out_* in T+1; a new grant takes 2 cycles (IDLE, KEY_RST).
// Backpressure: only the granted requester sees req_ready; no backpressure on the output side.
// Optional feature macro CIPHER_ARB_MAXLEN_EN: cut frames at MAX_LEN bytes and raise sticky err_trunc.
module cipher_frame_arbiter
  import cipher_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int MAX_LEN = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cipher_frame_arbiter_if.slave  req,
  output logic                   cph_rst,
  output logic [7:0]             cph_data,
  output logic                   cph_valid,
  input  logic [7:0]             cph_out_data,
  input  logic                   cph_out_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [IDW-1:0]         out_id,
  output logic                   busy,
  output logic                   err_trunc
);

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_ptr;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;

  logic           sel_valid;
  logic [7:0]     sel_data;
  logic           sel_last;
  logic           xfer;
  logic           trunc_hit;
  logic           frame_end;

  logic           sb_vld;
  logic           sb_last;
  logic [IDW-1:0] sb_id;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req (req.req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Route the granted requester's lane; ready only to the owner while streaming
  always_comb begin
    sel_valid     = 1'b0;
    sel_data      = '0;
    sel_last      = 1'b0;
    req.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_valid        = req.req_valid[i];
        sel_data         = req.req_data[8*i +: 8];
        sel_last         = req.req_last[i];
        req.req_ready[i] = rst_n && (state == STREAM);
      end
    end
  end

  // A transfer only happens on the owner's lane while streaming and out of reset
  assign xfer      = rst_n && (state == STREAM) && sel_valid;
  assign frame_end = xfer && (sel_last || trunc_hit);

`ifdef CIPHER_ARB_MAXLEN_EN
  localparam int LENW = $clog2(MAX_LEN + 1);

  logic [LENW-1:0] len_cnt;
  logic            err_q;

  // The MAX_LEN-th byte of a frame without req_last is forced to be the last one
  assign trunc_hit = xfer && !sel_last && (len_cnt == LENW'(MAX_LEN - 1));

  // Count bytes of the current frame and latch any truncation until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == KEY_RST) len_cnt <= '0;
      else if (xfer)        len_cnt <= len_cnt + 1'b1;
      if (trunc_hit)        err_q   <= 1'b1;
    end
  end

  assign err_trunc = rst_n && err_q;
`else
  logic unused_max_len;

  assign trunc_hit      = 1'b0;
  assign err_trunc      = 1'b0;
  assign unused_max_len = ^MAX_LEN;
`endif

  // Next-state logic: grant in IDLE, key resync, stream until last, one drain cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = KEY_RST;
      KEY_RST: state_nx = STREAM;
      STREAM:  if (frame_end) state_nx = DRAIN;
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, grant latch and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_any) grant <= pick_idx;
      if (state == DRAIN) rr_ptr <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Sideband travels alongside the cipher's one-cycle pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_vld  <= 1'b0;
      sb_last <= 1'b0;
      sb_id   <= '0;
    end else begin
      sb_vld <= xfer;
      if (xfer) begin
        sb_last <= sel_last || trunc_hit;
        sb_id   <= grant;
      end
    end
  end

  // The cipher is held in reset with the block and pulsed once per frame start
  assign cph_rst   = !rst_n || (state == KEY_RST);
  assign cph_valid = xfer;
  assign cph_data  = xfer ? sel_data : 8'h00;

  assign out_valid = rst_n && sb_vld && cph_out_valid;
  assign out_data  = cph_out_data;
  assign out_last  = rst_n && sb_last;
  assign out_id    = rst_n ? sb_id : '0;
  assign busy      = rst_n && (state != IDLE);

endmodule

// File: tb/tb_cipher_frame_arbiter.sv
// Self-checking bench for cipher_frame_arbiter driving random and directed frames through xor_cipher.
// Expected output is built from the frame-level rules: round-robin order, key phase 0 at each frame.
// Build with CIPHER_ARB_MAXLEN_EN to also exercise truncation at MAX_LEN=4.
module tb_cipher_frame_arbiter;
  import cipher_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
`ifdef CIPHER_ARB_MAXLEN_EN
  localparam int MAX_LEN = 4;
  localparam int LIMIT   = 4;
`else
  localparam int MAX_LEN = 256;
  localparam int LIMIT   = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } in_byte_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           last;
    logic [7:0]     data;
  } out_beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           cph_rst;
  logic [7:0]     cph_data;
  logic           cph_valid;
  logic [7:0]     cph_out_data;
  logic           cph_out_valid;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_last;
  logic [IDW-1:0] out_id;
  logic           busy;
  logic           err_trunc;

  cipher_frame_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  cipher_frame_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (bus.slave),
    .cph_rst       (cph_rst),
    .cph_data      (cph_data),
    .cph_valid     (cph_valid),
    .cph_out_data  (cph_out_data),
    .cph_out_valid (cph_out_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_id        (out_id),
    .busy          (busy),
    .err_trunc     (err_trunc)
  );

  xor_cipher u_cipher (
    .clk            (clk),
    .rst            (cph_rst),
    .data_in        (cph_data),
    .data_valid     (cph_valid),
    .data_out       (cph_out_data),
    .data_out_valid (cph_out_valid)
  );

  in_byte_t  src_q [NUM_REQ][$];
  out_beat_t got_q[$];
  out_beat_t exp_q[$];
  int        start_cyc[$];
  int        first_rdy_cyc;
  int        spurious_out;
  int        bad_ready;
  int        gap_after [NUM_REQ];
  int        gap_len   [NUM_REQ];
  int        hold_c    [NUM_REQ];
  bit        rand_gaps;
  int        m_ptr;
  int        n_checks;
  int        n_fail;

  function automatic logic [7:0] key_byte(input int pos);
    logic [31:0] k;
    k = 32'hDEADBEEF;
    return k[31 - 8*(pos % 4) -: 8];
  endfunction

  // Reference: split each requester's bytes into frames, then serve frames in round-robin order
  task automatic build_expected();
    in_byte_t  mq [NUM_REQ][$];
    in_byte_t  b;
    out_beat_t e;
    int        cnt;
    int        pos;
    int        r;
    bit        done;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = 0;
      for (int k = 0; k < src_q[i].size(); k++) begin
        b = src_q[i][k];
        cnt++;
        if (LIMIT > 0 && cnt == LIMIT) b.last = 1'b1;
        if (b.last) cnt = 0;
        mq[i].push_back(b);
      end
    end
    forever begin
      r = -1;
      for (int k = 0; k < NUM_REQ; k++)
        if (r < 0 && mq[(m_ptr + k) % NUM_REQ].size() > 0) r = (m_ptr + k) % NUM_REQ;
      if (r < 0) break;
      pos  = 0;
      done = 1'b0;
      while (!done && mq[r].size() > 0) begin
        b      = mq[r].pop_front();
        e.id   = IDW'(r);
        e.last = b.last;
        e.data = b.data ^ key_byte(pos);
        exp_q.push_back(e);
        pos++;
        done = b.last;
      end
      m_ptr = (r + 1) % NUM_REQ;
    end
  endtask

  task automatic load_frame(input int r, input int len, input bit zero);
    in_byte_t b;
    for (int k = 0; k < len; k++) begin
      b.data = zero ? 8'h00 : 8'($urandom);
      b.last = (k == len - 1);
      src_q[r].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < NUM_REQ; r++) begin
      if (hold_c[r] > 0) begin
        hold_c[r]--;
        bus.req_valid[r]        = 1'b0;
        bus.req_last[r]         = 1'b0;
        bus.req_data[8*r +: 8]  = 8'($urandom);
      end else if (src_q[r].size() > 0) begin
        bus.req_valid[r]        = 1'b1;
        bus.req_data[8*r +: 8]  = src_q[r][0].data;
        bus.req_last[r]         = src_q[r][0].last;
      end else begin
        bus.req_valid[r]        = 1'b0;
        bus.req_last[r]         = 1'b0;
        bus.req_data[8*r +: 8]  = 8'h00;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Play all queued bytes through the DUT, logging outputs and handshake timing
  task automatic run_traffic(input string name, input int max_cyc);
    bit       acc [NUM_REQ];
    int       cnt [NUM_REQ];
    bit       mid [NUM_REQ];
    bit       prev_xfer;
    bit       all_empty;
    int       tail;
    int       cyc;
    in_byte_t b;
    got_q.delete();
    start_cyc.delete();
    first_rdy_cyc = -1;
    spurious_out  = 0;
    bad_ready     = 0;
    prev_xfer     = 1'b0;
    tail          = 0;
    cyc           = 0;
    for (int r = 0; r < NUM_REQ; r++) begin
      cnt[r] = 0; mid[r] = 1'b0; hold_c[r] = 0;
    end
    @(posedge clk);
    #1 drive_inputs();
    forever begin
      @(negedge clk);
      if (out_valid) begin
        got_q.push_back('{id: out_id, last: out_last, data: out_data});
        if (!prev_xfer) spurious_out++;
      end
      prev_xfer = 1'b0;
      for (int r = 0; r < NUM_REQ; r++) begin
        acc[r] = bus.req_valid[r] && bus.req_ready[r];
        if (acc[r]) prev_xfer = 1'b1;
        if (acc[r] && cnt[r] == 0) start_cyc.push_back(cyc);
        if (bus.req_ready[r])
          for (int q = 0; q < NUM_REQ; q++) if (q != r && mid[q]) bad_ready++;
      end
      if (first_rdy_cyc < 0 && |bus.req_ready) first_rdy_cyc = cyc;
      all_empty = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) if (src_q[r].size() > 0) all_empty = 1'b0;
      if (all_empty) tail++;
      if (tail >= 5) break;
      if (cyc >= max_cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: still busy after %0d cycles, required completion", name, cyc);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (acc[r]) begin
          b = src_q[r].pop_front();
          cnt[r]++;
          if (b.last || (LIMIT > 0 && cnt[r] == LIMIT)) begin
            cnt[r] = 0;
            mid[r] = 1'b0;
          end else begin
            mid[r] = 1'b1;
            if (gap_after[r] == cnt[r]) hold_c[r] = gap_len[r];
            else if (rand_gaps && ($urandom % 4) == 0) hold_c[r] = $urandom_range(1, 3);
          end
        end
      end
      drive_inputs();
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cph_rst !== 1'b1)     begin n_fail++; $display("FAIL reset cph_rst: got %b want 1", cph_rst); end
    n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0", bus.req_ready); end
    n_checks++; if (cph_valid !== 1'b0)   begin n_fail++; $display("FAIL reset cph_valid: got %b want 0", cph_valid); end
    n_checks++; if (cph_data !== 8'h00)   begin n_fail++; $display("FAIL reset cph_data: got %h want 00", cph_data); end
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_last !== 1'b0)    begin n_fail++; $display("FAIL reset out_last: got %b want 0", out_last); end
    n_checks++; if (out_id !== '0)        begin n_fail++; $display("FAIL reset out_id: got %0d want 0", out_id); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++; if (err_trunc !== 1'b0)   begin n_fail++; $display("FAIL reset err_trunc: got %b want 0", err_trunc); end
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    n_checks++; if (cph_rst !== 1'b0) begin n_fail++; $display("FAIL post_reset cph_rst: got %b want 0", cph_rst); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL post_reset busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    logic [7:0] golden [5];
    golden = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE};
    load_frame(0, 5, 1'b1);
    build_expected();
    run_traffic("single_frame", 200);
    n_checks++;
    if (got_q.size() != 5) begin n_fail++; $display("FAIL single_frame count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_checks++;
      if (got_q[i] !== {2'd0, (i == 4), golden[i]}) begin
        n_fail++;
        $display("FAIL single_frame beat %0d: got id=%0d last=%b data=%h want id=0 last=%b data=%h",
                 i, got_q[i].id, got_q[i].last, got_q[i].data, (i == 4), golden[i]);
      end
    end
  endtask

  task automatic test_key_resync();
    load_frame(1, 3, 1'b1);
    load_frame(2, 2, 1'b1);
    build_expected();
    run_traffic("key_resync", 200);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL key_resync count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL key_resync beat %0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h",
                 i, got_q[i].id, got_q[i].last, got_q[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data);
      end
    end
    if (got_q.size() == 5) begin
      n_checks++;
      if (got_q[3].data !== 8'hDE || got_q[4].data !== 8'hAD || got_q[3].id !== 2'd2) begin
        n_fail++;
        $display("FAIL key_resync second_frame: got id=%0d %h,%h want id=2 DE,AD", got_q[3].id, got_q[3].data, got_q[4].data);
      end
    end
  endtask

  task automatic test_fairness();
    logic [IDW-1:0] ids [5];
    ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    for (int r = 0; r < NUM_REQ; r++) begin
      load_frame(r, 1, 1'b0);
      load_frame(r, 1, 1'b0);
    end
    build_expected();
    run_traffic("fairness", 400);
    n_checks++;
    if (first_rdy_cyc != 2) begin n_fail++; $display("FAIL fairness first_ready: got cycle %0d want 2", first_rdy_cyc); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].id !== ids[i]) begin n_fail++; $display("FAIL fairness order %0d: got id %0d want %0d", i, got_q[i].id, ids[i]); end
    end
    for (int i = 0; i + 1 < start_cyc.size() && i < 4; i++) begin
      n_checks++;
      if (start_cyc[i+1] - start_cyc[i] != 4) begin
        n_fail++;
        $display("FAIL fairness spacing %0d: got %0d cycles want 4", i, start_cyc[i+1] - start_cyc[i]);
      end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fairness count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL fairness beat %0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h",
                 i, got_q[i].id, got_q[i].last, got_q[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] golden [4];
    int         k;
    golden = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    gap_after[2] = 2;
    gap_len[2]   = 10;
    load_frame(2, 4, 1'b1);
    load_frame(0, 3, 1'b0);
    load_frame(1, 3, 1'b0);
    load_frame(3, 3, 1'b0);
    build_expected();
    run_traffic("stall", 500);
    gap_after[2] = -1;
    n_checks++;
    if (spurious_out != 0) begin n_fail++; $display("FAIL stall out_valid_in_gap: got %0d stray beats want 0", spurious_out); end
    n_checks++;
    if (bad_ready != 0) begin n_fail++; $display("FAIL stall foreign_ready: got %0d cycles want 0", bad_ready); end
    k = 0;
    foreach (got_q[i]) begin
      if (got_q[i].id == 2'd2 && k < 4) begin
        n_checks++;
        if (got_q[i].data !== golden[k]) begin n_fail++; $display("FAIL stall key_phase %0d: got %h want %h", k, got_q[i].data, golden[k]); end
        k++;
      end
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall beat %0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h",
                 i, got_q[i].id, got_q[i].last, got_q[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int accepted;
    int waited;
    accepted = 0;
    waited   = 0;
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    bus.req_data  = '0;
    bus.req_last  = '0;
    while (accepted < 2 && waited < 50) begin
      @(negedge clk);
      if (bus.req_valid[0] && bus.req_ready[0]) accepted++;
      waited++;
      if (accepted < 2) @(posedge clk);
    end
    n_checks++;
    if (accepted != 2) begin n_fail++; $display("FAIL reset_mid accept: got %0d bytes want 2", accepted); end
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++; if (cph_rst !== 1'b1)   begin n_fail++; $display("FAIL reset_mid cph_rst: got %b want 1", cph_rst); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid idle: busy %b want 0", busy); end
    load_frame(0, 2, 1'b1);
    build_expected();
    run_traffic("reset_mid", 200);
    n_checks++;
    if (got_q.size() != 2) begin n_fail++; $display("FAIL reset_mid count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_checks++;
      if (got_q[0] !== {2'd0, 1'b0, 8'hDE} || got_q[1] !== {2'd0, 1'b1, 8'hAD}) begin
        n_fail++;
        $display("FAIL reset_mid restart: got %h/%b,%h/%b want DE/0,AD/1", got_q[0].data, got_q[0].last, got_q[1].data, got_q[1].last);
      end
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      rand_gaps = 1'b1;
      for (int r = 0; r < NUM_REQ; r++)
        repeat ($urandom_range(0, 3)) load_frame(r, $urandom_range(1, 7), 1'b0);
      build_expected();
      run_traffic("random", 2000);
      rand_gaps = 1'b0;
      n_checks++;
      if (spurious_out != 0) begin n_fail++; $display("FAIL random latency: got %0d stray beats want 0", spurious_out); end
      n_checks++;
      if (bad_ready != 0) begin n_fail++; $display("FAIL random foreign_ready: got %0d cycles want 0", bad_ready); end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random beat %0d: got id=%0d last=%b data=%h want id=%0d last=%b data=%h",
                   i, got_q[i].id, got_q[i].last, got_q[i].data, exp_q[i].id, exp_q[i].last, exp_q[i].data);
        end
      end
    end
  endtask

`ifdef CIPHER_ARB_MAXLEN_EN
  task automatic test_maxlen();
    logic [7:0] golden [6];
    logic       lasts  [6];
    golden = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE, 8'hAD};
    lasts  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    load_frame(0, 6, 1'b1);
    build_expected();
    run_traffic("maxlen", 300);
    n_checks++;
    if (got_q.size() != 6) begin n_fail++; $display("FAIL maxlen count: got %0d want 6", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      n_checks++;
      if (got_q[i].data !== golden[i] || got_q[i].last !== lasts[i]) begin
        n_fail++;
        $display("FAIL maxlen beat %0d: got %h/%b want %h/%b", i, got_q[i].data, got_q[i].last, golden[i], lasts[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if (err_trunc !== 1'b1) begin n_fail++; $display("FAIL maxlen err_trunc: got %b want 1", err_trunc); end
  endtask
`else
  task automatic test_no_trunc();
    load_frame(1, 7, 1'b0);
    build_expected();
    run_traffic("no_trunc", 300);
    @(negedge clk);
    n_checks++;
    if (err_trunc !== 1'b0) begin n_fail++; $display("FAIL no_trunc err_trunc: got %b want 0", err_trunc); end
    n_checks++;
    if (got_q.size() != 7 || (got_q.size() == 7 && got_q[6].last !== 1'b1)) begin
      n_fail++;
      $display("FAIL no_trunc frame: got %0d beats want 7 with last on the final one", got_q.size());
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_ptr     = 0;
    rand_gaps = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      gap_after[r] = -1;
      gap_len[r]   = 0;
      hold_c[r]    = 0;
    end
    test_reset();
    test_single_frame();
    test_key_resync();
    test_fairness();
    test_stall();
    test_reset_mid_frame();
    test_random();
`ifdef CIPHER_ARB_MAXLEN_EN
    test_maxlen();
`else
    test_no_trunc();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cipher_frame_arbiter.md
# cipher_frame_arbiter

Shares the single `xor_cipher` datapath among NUM_REQ byte-stream requesters on a whole-frame basis. The block grants one requester at a time by round-robin and re-synchronises the cipher key phase to 0 at every frame start, so each frame is enciphered from the start of the 4-byte key. It also carries requester ID and end-of-frame sideband aligned to the cipher's one-cycle output latency. It sits between the per-channel receive front-ends and the downstream frame consumer.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- IDW, 2: width of requester ID; must satisfy 2**IDW >= NUM_REQ.
- MAX_LEN, 256: maximum frame length in bytes, used only with the length-check feature.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a frame.
- req_ready  out  NUM_REQ  per-requester accept.
- cph_rst  out  1  active-high reset to the cipher.
- cph_data  out  8  byte to the cipher.
- cph_valid  out  1  cipher data_valid.
- cph_out_data  in  8  cipher data_out.
- cph_out_valid  in  1  cipher data_out_valid.
- out_data  out  8  enciphered byte.
- out_valid  out  1  output strobe; there is no backpressure.
- out_last  out  1  last byte of the frame.
- out_id  out  IDW  requester that owns out_data.
- busy  out  1  high when the FSM is not in IDLE.
- err_trunc  out  1  sticky frame-truncation flag; constant 0 when the length-check feature is compiled out.

## Operation
- A byte transfers on requester i when req_valid[i] and req_ready[i] are both high in the same cycle.
- FSM states: IDLE, KEY_RST, STREAM, DRAIN.
- IDLE
  - If any req_valid is high, select the winner by searching upward from rr_ptr with wrap-around, latch the winner as grant, and go to KEY_RST.
  - Otherwise stay in IDLE.
- KEY_RST
  - cph_rst is high for exactly one cycle, which returns the cipher key index to 0.
  - Next state is STREAM.
- STREAM
  - req_ready[grant] = 1; all other req_ready bits are 0.
  - On each transfer: cph_valid = 1, cph_data = req_data[grant], and the length counter increments.
  - req_valid low mid-frame: stall in STREAM indefinitely; there is no timeout.
  - On a transfer with req_last: go to DRAIN.
- DRAIN
  - One cycle while the final enciphered byte emerges.
  - Set rr_ptr = grant+1, wrapping modulo NUM_REQ, then go to IDLE.
- Sideband register:
  - On each transfer, sb_last <= req_last (or forced last), sb_id <= grant, sb_vld <= 1.
  - Otherwise sb_vld <= 0.
- Output mapping:
  - out_valid = cph_out_valid & sb_vld.
  - out_data = cph_out_data.
  - out_last = sb_last.
  - out_id = sb_id.
- cph_rst = !rst_n | (state == KEY_RST), so the cipher is also held in reset while the block is in reset.
- Length counter width is $clog2(MAX_LEN+1) bits; it clears in KEY_RST.
- rst_n low at any point, including mid-frame:
  - Next cycle the block is in IDLE with rr_ptr=0, sb_vld=0, err_trunc=0.
  - Any partially sent frame is abandoned; no out_last is generated for it.
- Reset values: req_ready=0, cph_valid=0, cph_data=0, out_valid=0, out_last=0, out_id=0, busy=0, err_trunc=0, cph_rst=1 while rst_n is low.

## Timing
- Latency: a byte accepted in cycle T appears on out_valid/out_data in cycle T+1.
- Arbitration:
  - req_valid seen in IDLE at cycle T gives KEY_RST at T+1.
  - The first req_ready is high at T+2.
- Back-to-back frames:
  - Last byte accepted at T, DRAIN at T+1, IDLE at T+2.
  - The next frame's first byte is accepted no earlier than T+4.
- Single-byte frame (req_last on the first byte): follows the same path as any other frame, KEY_RST → STREAM → DRAIN.
- A requester that raises req_valid while another holds the grant waits; grants never change mid-frame.
- Requests that are already high when a frame ends compete in the next IDLE; the new rr_ptr gives the just-served requester the lowest priority.

## Configuration
- Macro: CIPHER_ARB_MAXLEN_EN.
- Defined:
  - When the length counter reaches MAX_LEN on a transfer without req_last, that byte is treated as last.
  - The sideband for that byte carries last=1, the FSM goes to DRAIN, and err_trunc is set and stays high until reset.
  - The requester's remaining bytes form a new frame when that requester is next granted.
- Not defined:
  - Frame length is unbounded and the counter is not instantiated.
  - err_trunc is tied to 0.

## Structure
- Package `cipher_arb_pkg`:
  - State enum {IDLE, KEY_RST, STREAM, DRAIN}.
  - Key phase constant KEY_LEN=4.
  - Helper function for ID width.
- Sub-module `rr_pick`: combinational round-robin picker with inputs req[NUM_REQ] and ptr[IDW], and outputs any and idx[IDW].
- Everything else (FSM, counters, sideband registers) lives in the top module. The bench instantiates `xor_cipher` alongside this block.

## Test plan
- Single frame: requester 0 sends 0x00,0x00,0x00,0x00,0x00 with last on the 5th byte → out_data DE,AD,BE,EF,DE; out_id=0; out_last on the 5th byte only.
- Key resync: requester 1 sends 3 bytes of 0x00, then requester 2 sends 2 bytes of 0x00 → second frame outputs DE,AD, proving the key phase returned to 0.
- Fairness: all four requesters continuously valid with 1-byte frames → out_id sequence 0,1,2,3,0; first req_ready 2 cycles after the request; frame starts 4 cycles apart.
- Stall: granted requester drops req_valid for 10 cycles mid-frame → no out_valid during the gap, other requesters get no req_ready, and the key phase continues unbroken.
- Reset mid-frame: rst_n low for 1 cycle after the 2nd byte → IDLE, cph_rst high for that cycle, next frame from requester 0 starts with 0xDE (input 0x00).
- CIPHER_ARB_MAXLEN_EN with MAX_LEN=4: 6-byte frame with no last until byte 6 → out_last on byte 4, err_trunc=1, bytes 5-6 re-enciphered as a new frame giving DE,AD.
